// File: rtl/clk_div_ratio_ctrl_if.sv
// Ratio-change bus between the requesters/register file and the controller.
// Handshake: a requester raises i_req_x and holds it, with i_ratio_x stable,
// until it sees o_ack_x high for exactly one cycle. It drops i_req_x in the
// cycle after the ack. There is no backpressure on the ack.
interface clk_div_ratio_ctrl_if;
  logic       i_en;
  logic       i_req_a;
  logic [7:0] i_ratio_a;
  logic       o_ack_a;
  logic       i_req_b;
  logic [7:0] i_ratio_b;
  logic       o_ack_b;
  logic [7:0] o_div_ratio;
  logic       o_clk_en;
  logic       o_busy;

  modport master (
    output i_en, i_req_a, i_ratio_a, i_req_b, i_ratio_b,
    input  o_ack_a, o_ack_b, o_div_ratio, o_clk_en, o_busy
  );

  modport slave (
    input  i_en, i_req_a, i_ratio_a, i_req_b, i_ratio_b,
    output o_ack_a, o_ack_b, o_div_ratio, o_clk_en, o_busy
  );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Round-robin sequencer for divider ratio changes. Each change gates the
// divider off for GATE_CYC cycles, loads the new ratio, re-enables it, waits
// one full divided period and then acknowledges the requester.
module clk_div_ratio_ctrl #(
  parameter int unsigned GATE_CYC  = 2,
  parameter logic [7:0]  DEF_RATIO = 8'd8
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst,
  clk_div_ratio_ctrl_if.slave  bus,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATE   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam int CNT_W = (GATE_CYC > 256) ? $clog2(GATE_CYC) : 8;
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       ratio_q, ratio_n;
  logic             grant_b, grant_n;
  logic             rr_b, rr_n;
  // Blocks arbitration in the first IDLE cycle after an ack so a requester's
  // stale (not yet dropped) request is never granted twice.
  logic             skip, skip_n;
  logic [7:0]       div_ratio, div_ratio_n;
  logic             clk_en, clk_en_n;
  logic             ack_a, ack_a_n;
  logic             ack_b, ack_b_n;
  logic             busy, busy_n;
  logic             pick_b;
  logic [7:0]       pick_ratio;

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ratio_n     = ratio_q;
    grant_n     = grant_b;
    rr_n        = rr_b;
    skip_n      = skip;
    div_ratio_n = div_ratio;
    clk_en_n    = clk_en;
    ack_a_n     = 1'b0;
    ack_b_n     = 1'b0;
    busy_n      = busy;
    pick_b      = bus.i_req_b && (!bus.i_req_a || rr_b);
    pick_ratio  = pick_b ? bus.i_ratio_b : bus.i_ratio_a;
    case (state)
      S_IDLE: begin
        clk_en_n = bus.i_en;
        busy_n   = 1'b0;
        skip_n   = 1'b0;
        if (!skip && bus.i_en && (bus.i_req_a || bus.i_req_b)) begin
          grant_n = pick_b;
          ratio_n = pick_ratio;
          busy_n  = 1'b1;
          if (pick_ratio == div_ratio) begin
            // Nothing to change: acknowledge without touching the divider.
            state_n  = S_ACK;
            clk_en_n = clk_en;
            ack_a_n  = !pick_b;
            ack_b_n  = pick_b;
          end else begin
            state_n  = S_GATE;
            clk_en_n = 1'b0;
            cnt_n    = GATE_LOAD;
          end
        end
      end
      S_GATE: begin
        clk_en_n = 1'b0;
        if (cnt == '0) state_n = S_LOAD;
        else           cnt_n   = cnt - CNT_ONE;
      end
      S_LOAD: begin
        div_ratio_n = ratio_q;
        clk_en_n    = bus.i_en;
        // Ratios 0 and 1 bypass the divider, so one cycle is a full period.
        cnt_n       = (ratio_q <= 8'd1) ? '0 : CNT_W'(ratio_q - 8'd1);
        state_n     = S_SETTLE;
      end
      S_SETTLE: begin
        clk_en_n = bus.i_en;
        if (cnt == '0) begin
          state_n = S_ACK;
          ack_a_n = !grant_b;
          ack_b_n = grant_b;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_ACK: begin
        clk_en_n = bus.i_en;
        rr_n     = !grant_b;
        busy_n   = 1'b0;
        skip_n   = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ratio_q   <= DEF_RATIO;
      grant_b   <= 1'b0;
      rr_b      <= 1'b0;
      skip      <= 1'b0;
      div_ratio <= DEF_RATIO;
      clk_en    <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ratio_q   <= ratio_n;
      grant_b   <= grant_n;
      rr_b      <= rr_n;
      skip      <= skip_n;
      div_ratio <= div_ratio_n;
      clk_en    <= clk_en_n;
      ack_a     <= ack_a_n;
      ack_b     <= ack_b_n;
      busy      <= busy_n;
    end
  end

  assign bus.o_ack_a     = ack_a;
  assign bus.o_ack_b     = ack_b;
  assign bus.o_div_ratio = div_ratio;
  assign bus.o_clk_en    = clk_en;
  assign bus.o_busy      = busy;
  assign o_state         = state;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Bench for clk_div_ratio_ctrl: directed scenarios followed by randomized
// request sequences, checked against a transaction-level timing model.
module tb_clk_div_ratio_ctrl;

  localparam int G = 2;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  int         checks;
  int         failures;

  // Reference model: current ratio and round-robin pointer (1 = B next).
  logic [7:0] m_ratio;
  logic       m_rr_b;

  clk_div_ratio_ctrl_if bus ();

  clk_div_ratio_ctrl #(.GATE_CYC(G), .DEF_RATIO(8'd8)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_state   (state_dbg)
  );

  // Clock and global watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with the divider expected enabled at the model ratio.
  task automatic idle_cycle();
    step();
    chk("idle_busy",   bus.o_busy, 0);
    chk("idle_ack_a",  bus.o_ack_a, 0);
    chk("idle_ack_b",  bus.o_ack_b, 0);
    chk("idle_clk_en", bus.o_clk_en, 1);
    chk("idle_ratio",  bus.o_div_ratio, m_ratio);
  endtask

  // Serves the request(s) currently driven, starting from the next edge.
  // Observation n (n edges after the call) corresponds to cycle k+n where
  // k is the edge at which the request is first sampled in IDLE. Returns
  // two cycles after the ack, which is the earliest next grant point.
  task automatic run_txn();
    logic       wb;
    logic [7:0] r;
    logic       chg;
    int         mr;
    int         l;
    wb  = bus.i_req_b && (!bus.i_req_a || m_rr_b);
    r   = wb ? bus.i_ratio_b : bus.i_ratio_a;
    chg = (r != m_ratio);
    mr  = (r > 8'd1) ? int'(r) : 1;
    l   = chg ? (G + 2 + mr) : 1;
    for (int n = 1; n <= l + 2; n++) begin
      step();
      chk("txn_ack_a",  bus.o_ack_a, (n == l) && !wb);
      chk("txn_ack_b",  bus.o_ack_b, (n == l) && wb);
      chk("txn_busy",   bus.o_busy, n <= l);
      chk("txn_clk_en", bus.o_clk_en, chg ? (n >= G + 2) : 1'b1);
      chk("txn_ratio",  bus.o_div_ratio, (chg && n >= G + 2) ? r : m_ratio);
      if (n == l) begin
        if (wb) bus.i_req_b = 1'b0;
        else    bus.i_req_a = 1'b0;
      end
    end
    m_ratio = r;
    m_rr_b  = !wb;
  endtask

  task automatic req_a(input logic [7:0] r);
    bus.i_req_a   = 1'b1;
    bus.i_ratio_a = r;
  endtask

  task automatic req_b(input logic [7:0] r);
    bus.i_req_b   = 1'b1;
    bus.i_ratio_b = r;
  endtask

  initial begin
    int         mode;
    logic [7:0] ra;
    logic [7:0] rb;
    checks        = 0;
    failures      = 0;
    m_ratio       = 8'd8;
    m_rr_b        = 1'b0;
    rst           = 1'b1;
    bus.i_en      = 1'b0;
    bus.i_req_a   = 1'b0;
    bus.i_ratio_a = 8'd0;
    bus.i_req_b   = 1'b0;
    bus.i_ratio_b = 8'd0;

    // Reset values.
    step();
    step();
    chk("rst_ratio",  bus.o_div_ratio, 8);
    chk("rst_clk_en", bus.o_clk_en, 0);
    chk("rst_ack_a",  bus.o_ack_a, 0);
    chk("rst_ack_b",  bus.o_ack_b, 0);
    chk("rst_busy",   bus.o_busy, 0);

    // Enable with no requests: divider enabled one cycle later.
    rst      = 1'b0;
    bus.i_en = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();

    // A -> 4: gate, load, ack at k+8.
    req_a(8'd4);
    run_txn();
    // B -> 8 moves the pointer back to A.
    req_b(8'd8);
    run_txn();
    // A requests the current ratio: ack at k+1, enable never drops.
    req_a(8'd8);
    run_txn();
    // B -> 2, leaving the pointer at A.
    req_b(8'd2);
    run_txn();
    chk("rr_ptr_a", m_rr_b, 0);

    // Simultaneous A=6, B=3: A first, then B.
    req_a(8'd6);
    req_b(8'd3);
    run_txn();
    chk("both_b_pending", bus.i_req_b, 1);
    run_txn();
    chk("both_final_ratio", bus.o_div_ratio, 3);

    // Divider bypass ratios use a one-cycle settle.
    req_b(8'd1);
    run_txn();
    req_b(8'd0);
    run_txn();

    // Master enable low: no grant, divider disabled.
    bus.i_en = 1'b0;
    req_b(8'd7);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en_lo_clk_en", bus.o_clk_en, 0);
      chk("en_lo_busy",   bus.o_busy, 0);
      chk("en_lo_ack_b",  bus.o_ack_b, 0);
      chk("en_lo_ratio",  bus.o_div_ratio, m_ratio);
    end
    bus.i_en = 1'b1;
    run_txn();

    // Reset during SETTLE; the held request is served again afterwards.
    req_a(8'd5);
    for (int n = 1; n <= G + 3; n++) step();
    chk("pre_rst_busy",  bus.o_busy, 1);
    chk("pre_rst_ratio", bus.o_div_ratio, 5);
    rst = 1'b1;
    step();
    chk("mid_rst_ratio",  bus.o_div_ratio, 8);
    chk("mid_rst_clk_en", bus.o_clk_en, 0);
    chk("mid_rst_ack_a",  bus.o_ack_a, 0);
    chk("mid_rst_busy",   bus.o_busy, 0);
    rst     = 1'b0;
    m_ratio = 8'd8;
    m_rr_b  = 1'b0;
    run_txn();

    // Randomized request sequences.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      ra   = 8'($urandom_range(0, 15));
      rb   = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = m_ratio;
      if ($urandom_range(0, 3) == 0) rb = m_ratio;
      if (mode != 1) req_a(ra);
      if (mode != 0) req_b(rb);
      run_txn();
      if (mode == 2) run_txn();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
    end
    chk("end_busy", bus.o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
